// File: rtl/mac_recv_pkg.sv
// mac_recv_pkg: shared types and constants for the receive MAC stage.
// FSM state enum, CRC-32 constants/update function, broadcast and VLAN TPID.
package mac_recv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DST,
        ST_SRC,
        ST_TYPE,
        ST_VLAN,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] VLAN_TPID     = 16'h8100;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_next(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_recv_if.sv
// mac_recv_if: byte stream in, parsed header and payload stream out.
// slave = MAC side, master = producer/consumer side; vlan_id with MAC_RECV_VLAN_EN.
interface mac_recv_if;
    import mac_recv_pkg::*;

    logic [7:0]  rx_data;
    logic        rx_active;
    logic [47:0] remote_mac;
    logic [15:0] ethertype;
    logic        is_broadcast;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        payload_sop;
    logic        frame_done;
    logic        frame_good;
`ifdef MAC_RECV_VLAN_EN
    logic [11:0] vlan_id;
`endif

    modport slave (
`ifdef MAC_RECV_VLAN_EN
        output vlan_id,
`endif
        input  rx_data, rx_active,
        output remote_mac, ethertype, is_broadcast,
        output payload_data, payload_valid, payload_sop,
        output frame_done, frame_good
    );

    modport master (
`ifdef MAC_RECV_VLAN_EN
        input  vlan_id,
`endif
        output rx_data, rx_active,
        input  remote_mac, ethertype, is_broadcast,
        input  payload_data, payload_valid, payload_sop,
        input  frame_done, frame_good
    );

endinterface

// File: rtl/mac_recv_crc32.sv
// crc32_byte: registered CRC-32 engine, one byte per clock.
// Ports: clk, rst_n, init (restart from CRC_INIT), enable, data[7:0], crc[31:0].
module crc32_byte
    import mac_recv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] base;

    // init and enable together fold the first byte into a fresh register.
    always_comb begin
        base  = init ? CRC_INIT : crc_q;
        crc_d = base;
        if (enable) begin
            crc_d = crc32_next(base, data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mac_recv.sv
// mac_recv: Ethernet RX parser after SFD; DST filter, SRC/type extract, FCS strip, CRC/length check.
// Ports: clock, reset_n, local_mac, accept_broadcast, rx (mac_recv_if.slave). VLAN: MAC_RECV_VLAN_EN.
module mac_recv
    import mac_recv_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [47:0] local_mac,
    input  logic        accept_broadcast,
    mac_recv_if.slave   rx
);

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [10:0]    cnt_q, cnt_d;
    logic           uni_q, uni_d;
    logic           bc_q, bc_d;
    logic [47:0]    src_q, src_d;
    logic [7:0]     thi_q, thi_d;
    logic [3:0][7:0] dl_q, dl_d;
    logic [2:0]     fill_q, fill_d;
    logic           first_q, first_d;
    logic [47:0]    remote_q, remote_d;
    logic [15:0]    etype_q, etype_d;
    logic           bcast_q, bcast_d;
    logic [7:0]     pdata_q, pdata_d;
    logic           pvalid_q, pvalid_d;
    logic           psop_q, psop_d;
    logic           done_q, done_d;
    logic           good_q, good_d;
`ifdef MAC_RECV_VLAN_EN
    logic [11:0]    vlan_q, vlan_d;
`endif

    logic           crc_init;
    logic           crc_en;
    logic [31:0]    crc;
    logic [2:0]     sel;
    logic           uni_hit;
    logic           bc_hit;
    logic           crc_ok;
    logic           len_ok;

    crc32_byte u_crc (
        .clk    (clock),
        .rst_n  (reset_n),
        .init   (crc_init),
        .enable (crc_en),
        .data   (rx.rx_data),
        .crc    (crc)
    );

    // Byte lane of the address under test; IDLE always handles byte 0.
    assign sel     = (state_q == ST_IDLE) ? 3'd5 : (3'd5 - idx_q);
    assign uni_hit = rx.rx_data == 8'(local_mac >> {sel, 3'b000});
    assign bc_hit  = accept_broadcast
                   && (rx.rx_data == 8'(BROADCAST_MAC >> {sel, 3'b000}));
    assign crc_ok  = crc == CRC_RESIDUE;
    assign len_ok  = (cnt_q >= 11'(MIN_FRAME)) && (cnt_q <= 11'(MAX_FRAME));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        uni_d    = uni_q;
        bc_d     = bc_q;
        src_d    = src_q;
        thi_d    = thi_q;
        dl_d     = dl_q;
        fill_d   = fill_q;
        first_d  = first_q;
        remote_d = remote_q;
        etype_d  = etype_q;
        bcast_d  = bcast_q;
        pdata_d  = pdata_q;
        pvalid_d = 1'b0;
        psop_d   = 1'b0;
        done_d   = 1'b0;
        good_d   = 1'b0;
        crc_init = 1'b0;
        crc_en   = 1'b0;
`ifdef MAC_RECV_VLAN_EN
        vlan_d   = vlan_q;
`endif

        if (rx.rx_active && (cnt_q != 11'h7FF)) begin
            cnt_d = cnt_q + 11'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rx.rx_active) begin
                    crc_init = 1'b1;
                    crc_en   = 1'b1;
                    cnt_d    = 11'd1;
                    uni_d    = uni_hit;
                    bc_d     = bc_hit;
                    idx_d    = 3'd1;
                    fill_d   = 3'd0;
                    first_d  = 1'b1;
                    state_d  = (uni_hit || bc_hit) ? ST_DST : ST_DROP;
                end
            end
            ST_DST: begin
                if (!rx.rx_active) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    crc_en = 1'b1;
                    uni_d  = uni_q && uni_hit;
                    bc_d   = bc_q && bc_hit;
                    if (!(uni_d || bc_d)) begin
                        state_d = ST_DROP;
                    end else if (idx_q == 3'd5) begin
                        state_d = ST_SRC;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_SRC: begin
                if (!rx.rx_active) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    crc_en = 1'b1;
                    src_d  = {src_q[39:0], rx.rx_data};
                    if (idx_q == 3'd5) begin
                        state_d = ST_TYPE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_TYPE: begin
                if (!rx.rx_active) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    crc_en = 1'b1;
                    if (idx_q == 3'd0) begin
                        thi_d = rx.rx_data;
                        idx_d = 3'd1;
                    end else begin
                        remote_d = src_q;
                        etype_d  = {thi_q, rx.rx_data};
                        bcast_d  = bc_q;
                        idx_d    = 3'd0;
`ifdef MAC_RECV_VLAN_EN
                        if ({thi_q, rx.rx_data} == VLAN_TPID) begin
                            state_d = ST_VLAN;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
`else
                        state_d = ST_PAYLOAD;
`endif
                    end
                end
            end
            ST_VLAN: begin
`ifdef MAC_RECV_VLAN_EN
                if (!rx.rx_active) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    crc_en = 1'b1;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == 3'd0) begin
                        vlan_d[11:8] = rx.rx_data[3:0];
                    end else if (idx_q == 3'd1) begin
                        vlan_d[7:0] = rx.rx_data;
                    end else if (idx_q == 3'd2) begin
                        thi_d = rx.rx_data;
                    end else begin
                        etype_d = {thi_q, rx.rx_data};
                        state_d = ST_PAYLOAD;
                    end
                end
`else
                state_d = ST_DROP;
`endif
            end
            ST_PAYLOAD: begin
                if (rx.rx_active) begin
                    crc_en = 1'b1;
                    dl_d   = {dl_q[2:0], rx.rx_data};
                    // Release the oldest byte only once 4 newer ones exist,
                    // so the trailing FCS never leaves the delay line.
                    if (fill_q == 3'd4) begin
                        pvalid_d = 1'b1;
                        pdata_d  = dl_q[3];
                        psop_d   = first_q;
                        first_d  = 1'b0;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end else begin
                    done_d  = 1'b1;
                    good_d  = crc_ok && len_ok;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!rx.rx_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_DROP;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_DROP;
            idx_q    <= '0;
            cnt_q    <= '0;
            uni_q    <= 1'b0;
            bc_q     <= 1'b0;
            src_q    <= '0;
            thi_q    <= '0;
            dl_q     <= '0;
            fill_q   <= '0;
            first_q  <= 1'b0;
            remote_q <= '0;
            etype_q  <= '0;
            bcast_q  <= 1'b0;
            pdata_q  <= '0;
            pvalid_q <= 1'b0;
            psop_q   <= 1'b0;
            done_q   <= 1'b0;
            good_q   <= 1'b0;
`ifdef MAC_RECV_VLAN_EN
            vlan_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            uni_q    <= uni_d;
            bc_q     <= bc_d;
            src_q    <= src_d;
            thi_q    <= thi_d;
            dl_q     <= dl_d;
            fill_q   <= fill_d;
            first_q  <= first_d;
            remote_q <= remote_d;
            etype_q  <= etype_d;
            bcast_q  <= bcast_d;
            pdata_q  <= pdata_d;
            pvalid_q <= pvalid_d;
            psop_q   <= psop_d;
            done_q   <= done_d;
            good_q   <= good_d;
`ifdef MAC_RECV_VLAN_EN
            vlan_q   <= vlan_d;
`endif
        end
    end

    assign rx.remote_mac    = remote_q;
    assign rx.ethertype     = etype_q;
    assign rx.is_broadcast  = bcast_q;
    assign rx.payload_data  = pdata_q;
    assign rx.payload_valid = pvalid_q;
    assign rx.payload_sop   = psop_q;
    assign rx.frame_done    = done_q;
    assign rx.frame_good    = good_q;
`ifdef MAC_RECV_VLAN_EN
    assign rx.vlan_id       = vlan_q;
`endif

endmodule

// File: tb/tb_mac_recv.sv
// tb_mac_recv: directed frames into mac_recv, collected outputs checked
// against hand-derived expectations.
module tb_mac_recv;

    localparam logic [47:0] LMAC = 48'h0200_0000_0001;
    localparam logic [47:0] SMAC = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] BMAC = 48'hFFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [47:0] local_mac = LMAC;
    logic        accept_broadcast = 1'b0;

    mac_recv_if bus ();

    mac_recv dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .local_mac        (local_mac),
        .accept_broadcast (accept_broadcast),
        .rx               (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    logic [7:0] frm[$];
    logic [7:0] pq[$];
    int         done_cnt = 0;
    int         sop_cnt = 0;
    int         both_cnt = 0;
    logic       last_good = 1'b0;
    logic [7:0] sop_byte = 8'h00;
    longint     sop_t = 0;
    longint     t14 = 0;

    int b_pq, b_done, b_sop, b_both;

    always @(negedge clock) begin
        if (bus.payload_valid) begin
            pq.push_back(bus.payload_data);
            if (bus.payload_sop) begin
                sop_cnt++;
                sop_byte = bus.payload_data;
                sop_t = $time;
            end
        end
        if (bus.frame_done) begin
            done_cnt++;
            last_good = bus.frame_good;
        end
        if (bus.frame_done && bus.payload_valid) begin
            both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic snap();
        b_pq   = pq.size();
        b_done = done_cnt;
        b_sop  = sop_cnt;
        b_both = both_cnt;
    endtask

    task automatic build(input logic [47:0] dst, input logic [15:0] et,
                         input int plen);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(SMAC[47-8*i -: 8]);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(8'(i));
    endtask

    task automatic add_fcs();
        logic [31:0] c;
        logic [31:0] f;
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c = c ^ {24'd0, frm[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        f = ~c;
        frm.push_back(f[7:0]);
        frm.push_back(f[15:8]);
        frm.push_back(f[23:16]);
        frm.push_back(f[31:24]);
    endtask

    // cut: stop after this many bytes (-1 none); rst_at: reset for 2 cycles.
    task automatic send(input int cut, input int rst_at, input int gap);
        for (int i = 0; i < frm.size(); i++) begin
            if (cut >= 0 && i == cut) break;
            if (rst_at >= 0 && i == rst_at) reset_n = 1'b0;
            if (rst_at >= 0 && i == rst_at + 2) begin
                reset_n = 1'b1;
                snap();
            end
            if (i == 14) t14 = $time;
            bus.rx_active = 1'b1;
            bus.rx_data = frm[i];
            cyc();
        end
        bus.rx_active = 1'b0;
        bus.rx_data = 8'h00;
        repeat (gap) cyc();
    endtask

    function automatic int pay_errs(input int n);
        int e;
        e = 0;
        if (pq.size() - b_pq != n) return 999;
        for (int k = 0; k < n; k++) begin
            if (pq[b_pq + k] !== 8'(k)) e++;
        end
        return e;
    endfunction

    initial begin
        bus.rx_active = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) cyc();
        chk("rst_pvalid", 64'(bus.payload_valid), 0);
        chk("rst_done", 64'(bus.frame_done), 0);
        chk("rst_remote", 64'(bus.remote_mac), 0);
        chk("rst_etype", 64'(bus.ethertype), 0);
        chk("rst_bcast", 64'(bus.is_broadcast), 0);
        reset_n = 1'b1;
        repeat (2) cyc();

        build(LMAC, 16'h0800, 46);
        add_fcs();
        snap();
        send(-1, -1, 4);
        chk("t1_done", 64'(done_cnt - b_done), 1);
        chk("t1_good", 64'(last_good), 1);
        chk("t1_bytes", 64'(pay_errs(46)), 0);
        chk("t1_sop_cnt", 64'(sop_cnt - b_sop), 1);
        chk("t1_sop_byte", 64'(sop_byte), 0);
        chk("t1_latency", 64'(sop_t - t14), 54);
        chk("t1_etype", 64'(bus.ethertype), 64'h0800);
        chk("t1_remote", 64'(bus.remote_mac), 64'(SMAC));
        chk("t1_bcast", 64'(bus.is_broadcast), 0);
        chk("t1_done_pv", 64'(both_cnt - b_both), 0);

        build(LMAC, 16'h0800, 46);
        add_fcs();
        frm[20] = frm[20] ^ 8'h01;
        snap();
        send(-1, -1, 4);
        chk("t2_count", 64'(pq.size() - b_pq), 46);
        chk("t2_flip", 64'(pq[b_pq + 6]), 64'h07);
        chk("t2_done", 64'(done_cnt - b_done), 1);
        chk("t2_good", 64'(last_good), 0);

        build(48'h0200_0000_0002, 16'h0800, 46);
        add_fcs();
        snap();
        send(-1, -1, 4);
        chk("t3_done", 64'(done_cnt - b_done), 0);
        chk("t3_count", 64'(pq.size() - b_pq), 0);
        build(LMAC, 16'h0800, 46);
        add_fcs();
        snap();
        send(-1, -1, 4);
        chk("t3_next_done", 64'(done_cnt - b_done), 1);
        chk("t3_next_good", 64'(last_good), 1);

        build(BMAC, 16'h0806, 46);
        add_fcs();
        snap();
        send(-1, -1, 4);
        chk("t4_bc_off", 64'(done_cnt - b_done), 0);
        chk("t4_bc_off_cnt", 64'(pq.size() - b_pq), 0);
        accept_broadcast = 1'b1;
        snap();
        send(-1, -1, 4);
        chk("t4_bc_done", 64'(done_cnt - b_done), 1);
        chk("t4_bc_good", 64'(last_good), 1);
        chk("t4_bc_flag", 64'(bus.is_broadcast), 1);
        chk("t4_bc_etype", 64'(bus.ethertype), 64'h0806);
        accept_broadcast = 1'b0;

        build(LMAC, 16'h0800, 42);
        add_fcs();
        snap();
        send(-1, -1, 4);
        chk("t5_runt_done", 64'(done_cnt - b_done), 1);
        chk("t5_runt_good", 64'(last_good), 0);
        chk("t5_runt_bytes", 64'(pay_errs(42)), 0);
        build(LMAC, 16'h0800, 1500);
        add_fcs();
        snap();
        send(-1, -1, 4);
        chk("t5_max_good", 64'(last_good), 1);
        chk("t5_max_done", 64'(done_cnt - b_done), 1);
        build(LMAC, 16'h0800, 1501);
        add_fcs();
        snap();
        send(-1, -1, 4);
        chk("t5_long_done", 64'(done_cnt - b_done), 1);
        chk("t5_long_good", 64'(last_good), 0);

        build(LMAC, 16'h0800, 46);
        add_fcs();
        snap();
        send(10, -1, 4);
        chk("t6_cut_done", 64'(done_cnt - b_done), 1);
        chk("t6_cut_good", 64'(last_good), 0);
        chk("t6_cut_cnt", 64'(pq.size() - b_pq), 0);

        build(LMAC, 16'h0800, 46);
        add_fcs();
        snap();
        send(-1, -1, 1);
        send(-1, -1, 4);
        chk("t7_b2b_done", 64'(done_cnt - b_done), 2);
        chk("t7_b2b_good", 64'(last_good), 1);
        chk("t7_b2b_cnt", 64'(pq.size() - b_pq), 92);
        chk("t7_b2b_sop", 64'(sop_cnt - b_sop), 2);
        chk("t7_b2b_pv", 64'(both_cnt - b_both), 0);

        snap();
        send(-1, 30, 4);
        chk("t8_rst_done", 64'(done_cnt - b_done), 0);
        chk("t8_rst_cnt", 64'(pq.size() - b_pq), 0);
        snap();
        send(-1, -1, 4);
        chk("t8_next_done", 64'(done_cnt - b_done), 1);
        chk("t8_next_good", 64'(last_good), 1);
        chk("t8_next_bytes", 64'(pay_errs(46)), 0);

`ifndef MAC_RECV_VLAN_EN
        build(LMAC, 16'h8100, 46);
        add_fcs();
        snap();
        send(-1, -1, 4);
        chk("t9_vlan_etype", 64'(bus.ethertype), 64'h8100);
        chk("t9_vlan_bytes", 64'(pay_errs(46)), 0);
        chk("t9_vlan_good", 64'(last_good), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
